// File: rtl/common_dffram_2a1w1r.sv
// DFF-based simple-dual-port RAM: one write port (A), one read port (B).
// Address encoding per port is selectable (one-hot or binary); tdout exposes every entry.
module common_dffram_2a1w1r #(
    parameter int RAM_DATA_WIDTH          = 8,
    parameter int RAM_DEPTH               = 4,
    parameter int PORTA_ONEHOT_ADDRESSING = 1,
    parameter int PORTB_ONEHOT_ADDRESSING = 1,
    parameter int PORTA_BIT_WRITE_ENABLE  = 0,
    parameter int DATA_COUPLED            = 0,
    localparam int AW_A = (PORTA_ONEHOT_ADDRESSING != 0) ? RAM_DEPTH : $clog2(RAM_DEPTH),
    localparam int AW_B = (PORTB_ONEHOT_ADDRESSING != 0) ? RAM_DEPTH : $clog2(RAM_DEPTH),
    localparam int WE_W = (PORTA_BIT_WRITE_ENABLE != 0) ? RAM_DATA_WIDTH : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ena,
    input  logic [WE_W-1:0]                   wea,
    input  logic [AW_A-1:0]                   addra,
    input  logic [RAM_DATA_WIDTH-1:0]         dina,
    input  logic [AW_B-1:0]                   addrb,
    output logic [RAM_DATA_WIDTH-1:0]         doutb,
    output logic [RAM_DEPTH*RAM_DATA_WIDTH-1:0] tdout
);

    logic [RAM_DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_DEPTH-1:0]      w_sel_a;
    logic [RAM_DATA_WIDTH-1:0] w_bit_we;
    logic [RAM_DATA_WIDTH-1:0] w_rdata;

    if (PORTA_BIT_WRITE_ENABLE != 0) begin : g_bit_we
        assign w_bit_we = wea;
    end else begin : g_word_we
        assign w_bit_we = {RAM_DATA_WIDTH{wea[0]}};
    end

    for (genvar i = 0; i < RAM_DEPTH; i++) begin : g_entry
        if (PORTA_ONEHOT_ADDRESSING != 0) begin : g_oh
            assign w_sel_a[i] = addra[i];
        end else begin : g_bin
            assign w_sel_a[i] = (addra == AW_A'(i));
        end

        // Entry storage with a masked write; reset is a synchronous clear.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_mem[i] <= {RAM_DATA_WIDTH{1'b0}};
            end else if (ena && w_sel_a[i]) begin
                r_mem[i] <= (r_mem[i] & ~w_bit_we) | (dina & w_bit_we);
            end
        end

        assign tdout[i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH] = r_mem[i];
    end

    if (PORTB_ONEHOT_ADDRESSING != 0) begin : g_rd_oh
        // One-hot read mux: AND-OR over all entries.
        always_comb begin
            w_rdata = {RAM_DATA_WIDTH{1'b0}};
            for (int i = 0; i < RAM_DEPTH; i++) begin
                w_rdata = w_rdata | (r_mem[i] & {RAM_DATA_WIDTH{addrb[i]}});
            end
        end
    end else begin : g_rd_bin
        assign w_rdata = r_mem[addrb];
    end

    if (DATA_COUPLED != 0) begin : g_rd_reg
        logic [RAM_DATA_WIDTH-1:0] r_doutb;
        // Registered read data for timing-critical consumers.
        always_ff @(posedge clk) begin
            r_doutb <= w_rdata;
        end
        assign doutb = r_doutb;
    end else begin : g_rd_comb
        assign doutb = w_rdata;
    end

endmodule

// File: rtl/common_dffram_fifo.sv
// First-word-fall-through FIFO over the DFF RAM, using one-hot read/write pointers
// so the RAM needs no address decode.
module common_dffram_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [DEPTH-1:0]     PTR_RESET = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);

    function automatic logic [DEPTH-1:0] rotl(input logic [DEPTH-1:0] p);
        return {p[DEPTH-2:0], p[DEPTH-1]};
    endfunction

    logic [DEPTH-1:0]     r_wptr;
    logic [DEPTH-1:0]     r_rptr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [DEPTH-1:0]     w_wptr_nxt;
    logic [DEPTH-1:0]     w_rptr_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DEPTH*DATA_WIDTH-1:0] w_tdout_unused;

    assign w_full  = (r_cnt == CNT_FULL);
    assign w_empty = (r_cnt == {CNT_WIDTH{1'b0}});
    assign w_push  = s_valid & ~w_full & ~flush;
    assign w_pop   = m_ready & ~w_empty & ~flush;

    assign s_ready = ~w_full;
    assign m_valid = ~w_empty;
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_cnt;

    // Next pointer and occupancy values from the push/pop pair.
    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cnt_nxt  = r_cnt;
        if (w_push) begin
            w_wptr_nxt = rotl(r_wptr);
        end else begin
            w_wptr_nxt = r_wptr;
        end
        if (w_pop) begin
            w_rptr_nxt = rotl(r_rptr);
        end else begin
            w_rptr_nxt = r_rptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_WIDTH'(1'b1);
            2'b01:   w_cnt_nxt = r_cnt - CNT_WIDTH'(1'b1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Pointer/count state; flush wins over any transfer in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= PTR_RESET;
            r_rptr <= PTR_RESET;
            r_cnt  <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            r_wptr <= PTR_RESET;
            r_rptr <= PTR_RESET;
            r_cnt  <= {CNT_WIDTH{1'b0}};
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    common_dffram_2a1w1r #(
        .RAM_DATA_WIDTH          (DATA_WIDTH),
        .RAM_DEPTH               (DEPTH),
        .PORTA_ONEHOT_ADDRESSING (1),
        .PORTB_ONEHOT_ADDRESSING (1),
        .PORTA_BIT_WRITE_ENABLE  (0),
        .DATA_COUPLED            (0)
    ) u_ram (
        .clk   (clk),
        .reset (1'b0),
        .ena   (w_push),
        .wea   (w_push),
        .addra (r_wptr),
        .dina  (s_data),
        .addrb (r_rptr),
        .doutb (m_data),
        .tdout (w_tdout_unused)
    );

endmodule

// File: tb/tb_common_dffram_fifo.sv
// Directed bench for common_dffram_fifo (DATA_WIDTH=8, DEPTH=4).
module tb_common_dffram_fifo;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int vectors;
    int miscompares;

    common_dffram_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_s_ready got %b want 1", s_ready); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        vectors++; if (full !== 1'b0)    begin miscompares++; $display("FAIL rst_full got %b want 0", full); end
        vectors++; if (empty !== 1'b1)   begin miscompares++; $display("FAIL rst_empty got %b want 1", empty); end
        vectors++; if (count !== 3'd0)   begin miscompares++; $display("FAIL rst_count got %0d want 0", count); end
        @(negedge clk);
        reset = 1'b1;
        cyc();
        vectors++; if (empty !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL post_rst got empty=%b count=%0d want 1/0", empty, count); end
    endtask

    task automatic test_single();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass got m_valid=%b want 0", m_valid); end
        cyc();
        s_valid = 1'b0;
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_m_valid got %b want 1", m_valid); end
        vectors++; if (m_data !== 8'hA5) begin miscompares++; $display("FAIL single_m_data got %h want a5", m_data); end
        vectors++; if (count !== 3'd1)   begin miscompares++; $display("FAIL single_count got %0d want 1", count); end
        vectors++; if (empty !== 1'b0)   begin miscompares++; $display("FAIL single_empty got %b want 0", empty); end
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        vectors++; if (empty !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL single_pop got empty=%b count=%0d want 1/0", empty, count); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h11 * (i + 1));
            cyc();
        end
        vectors++; if (full !== 1'b1)    begin miscompares++; $display("FAIL fill_full got %b want 1", full); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL fill_s_ready got %b want 0", s_ready); end
        vectors++; if (count !== 3'd4)   begin miscompares++; $display("FAIL fill_count got %0d want 4", count); end
        s_data = 8'h55;
        cyc();
        s_valid = 1'b0;
        vectors++; if (count !== 3'd4)   begin miscompares++; $display("FAIL fill_overflow_count got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(8'h11 * (i + 1));
            vectors++; if (m_valid !== 1'b1 || m_data !== exp_d) begin miscompares++; $display("FAIL fill_drain%0d got v=%b d=%h want 1/%h", i, m_valid, m_data, exp_d); end
            m_ready = 1'b1;
            cyc();
        end
        m_ready = 1'b0;
        vectors++; if (empty !== 1'b1)   begin miscompares++; $display("FAIL fill_drained_empty got %b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_d;
        s_valid = 1'b1; s_data = 8'h80; cyc();
        s_data = 8'h81; cyc();
        for (int k = 0; k < 10; k++) begin
            s_data = 8'(8'h82 + k);
            m_ready = 1'b1;
            exp_d = 8'(8'h80 + k);
            vectors++; if (m_data !== exp_d) begin miscompares++; $display("FAIL simul_order%0d got %h want %h", k, m_data, exp_d); end
            cyc();
            vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL simul_count%0d got %0d want 2", k, count); end
        end
        s_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_d = 8'(8'h8A + k);
            vectors++; if (m_valid !== 1'b1 || m_data !== exp_d) begin miscompares++; $display("FAIL simul_tail%0d got v=%b d=%h want 1/%h", k, m_valid, m_data, exp_d); end
            cyc();
        end
        m_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL simul_empty got %b want 1", empty); end
    endtask

    task automatic test_pop_full();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h90 + i); cyc();
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL popfull_full got %b want 1", full); end
        s_data = 8'h94; m_ready = 1'b1;
        vectors++; if (m_data !== 8'h90) begin miscompares++; $display("FAIL popfull_head got %h want 90", m_data); end
        cyc();
        s_valid = 1'b0; m_ready = 1'b0;
        vectors++; if (count !== 3'd3)   begin miscompares++; $display("FAIL popfull_count got %0d want 3", count); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL popfull_s_ready got %b want 1", s_ready); end
        vectors++; if (m_data !== 8'h91) begin miscompares++; $display("FAIL popfull_next got %h want 91", m_data); end
    endtask

    task automatic test_flush();
        flush = 1'b1; s_valid = 1'b1; m_ready = 1'b1; s_data = 8'hEE;
        cyc();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        vectors++; if (count !== 3'd0)   begin miscompares++; $display("FAIL flush_count got %0d want 0", count); end
        vectors++; if (empty !== 1'b1)   begin miscompares++; $display("FAIL flush_empty got %b want 1", empty); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL flush_m_valid got %b want 0", m_valid); end
        s_valid = 1'b1; s_data = 8'h7E;
        cyc();
        s_valid = 1'b0;
        vectors++; if (m_valid !== 1'b1 || m_data !== 8'h7E || count !== 3'd1) begin miscompares++; $display("FAIL flush_push got v=%b d=%h c=%0d want 1/7e/1", m_valid, m_data, count); end
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL flush_pop_empty got %b want 1", empty); end
    endtask

    task automatic test_async_reset();
        s_valid = 1'b1; s_data = 8'h31; cyc();
        s_data = 8'h32; cyc();
        s_valid = 1'b0;
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL arst_pre_count got %0d want 2", count); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (count !== 3'd0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin miscompares++; $display("FAIL arst_immediate got c=%0d sr=%b mv=%b want 0/1/0", count, s_ready, m_valid); end
        s_valid = 1'b1; s_data = 8'h99;
        cyc(); cyc();
        vectors++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL arst_hold got c=%0d e=%b f=%b want 0/1/0", count, empty, full); end
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        s_valid = 1'b1; s_data = 8'h5A;
        cyc();
        s_valid = 1'b0;
        vectors++; if (m_valid !== 1'b1 || m_data !== 8'h5A || count !== 3'd1) begin miscompares++; $display("FAIL arst_after got v=%b d=%h c=%0d want 1/5a/1", m_valid, m_data, count); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_simultaneous();
        test_pop_full();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
